reg_bank_driver: RTL and testbench

REG_BANK_DRIVER -- requirements
Module: reg_bank_driver

---
 rtl/reg_bank_driver_pkg.sv | 13 +
 rtl/reg_bank_storage.sv | 35 +++
 rtl/reg_bank_driver.sv | 111 +++++++++++
 tb/tb_reg_bank_driver.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/reg_bank_driver_pkg.sv
// Shared types and defaults for the register bank operand driver.
package reg_bank_driver_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

endpackage

// File: rtl/reg_bank_storage.sv
// Register array with one synchronous write port and two asynchronous read ports.
module reg_bank_storage
    import reg_bank_driver_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b
);

    logic [WIDTH-1:0] regs [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/reg_bank_driver.sv
// Captures two register operands per accepted read and drives them onto shared
// tri-state buses once bus_grant allows, one enable cycle per request.
module reg_bank_driver
    import reg_bank_driver_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_req,
    output logic                     rd_ready,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_a,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_b,
    input  logic                     bus_grant,
    output logic [WIDTH-1:0]         bus_a_data,
    output logic [WIDTH-1:0]         bus_b_data,
    output logic                     bus_a_en,
    output logic                     bus_b_en
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             en_q;
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;

    reg_bank_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and ready decode
    always_comb begin
        state_d  = state_q;
        rd_ready = 1'b0;
        accept   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DRIVE: begin
                rd_ready = 1'b1;
                accept   = rd_req;
                if (rd_req) begin
                    state_d = bus_grant ? ST_DRIVE : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus_grant) begin
                    state_d = ST_DRIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A write landing on a read address in the accept cycle wins over the stored value
    always_comb begin
        cap_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_data : rd_data_a;
        cap_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_data : rd_data_b;
    end

    // Operand snapshots and enable, registered so the buffers see clean edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_a_data <= '0;
            bus_b_data <= '0;
            en_q       <= 1'b0;
        end else begin
            en_q <= (state_d == ST_DRIVE);
            if (accept) begin
                bus_a_data <= cap_a;
                bus_b_data <= cap_b;
            end
        end
    end

    assign bus_a_en = en_q;
    assign bus_b_en = en_q;

endmodule

// File: tb/tb_reg_bank_driver.sv
// Directed self-checking bench for reg_bank_driver.
module tb_reg_bank_driver;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_req;
    logic        rd_ready;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic        bus_grant;
    logic [15:0] bus_a_data;
    logic [15:0] bus_b_data;
    logic        bus_a_en;
    logic        bus_b_en;

    int errors = 0;
    int checks = 0;

    reg_bank_driver #(.WIDTH(16), .DEPTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .rd_ready   (rd_ready),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .bus_grant  (bus_grant),
        .bus_a_data (bus_a_data),
        .bus_b_data (bus_b_data),
        .bus_a_en   (bus_a_en),
        .bus_b_en   (bus_b_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic en, input logic rdy);
        chk({tag, "_en_a"}, 16'(bus_a_en), 16'(en));
        chk({tag, "_en_b"}, 16'(bus_b_en), 16'(en));
        chk({tag, "_rdy"},  16'(rd_ready), 16'(rdy));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = 1'b0; rd_addr_a = '0; rd_addr_b = '0; bus_grant = 1'b0;
        cyc(); cyc();
        chk("rst_a", bus_a_data, 16'h0000);
        chk("rst_b", bus_b_data, 16'h0000);
        chk_ctl("rst", 1'b0, 1'b1);
        rst_n = 1'b1;

        // First accept right after reset release
        rd_req = 1'b1; rd_addr_a = 4'd3; rd_addr_b = 4'd7; bus_grant = 1'b1;
        cyc();
        rd_req = 1'b0;
        chk_ctl("first", 1'b1, 1'b1);
        chk("first_a", bus_a_data, 16'h0000);
        chk("first_b", bus_b_data, 16'h0000);
        cyc();
        chk_ctl("first_idle", 1'b0, 1'b1);

        // Write r3 then read it on both buses
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
        cyc();
        wr_en = 1'b0;
        rd_req = 1'b1; rd_addr_a = 4'd3; rd_addr_b = 4'd3;
        cyc();
        rd_req = 1'b0;
        chk_ctl("same", 1'b1, 1'b1);
        chk("same_a", bus_a_data, 16'hBEEF);
        chk("same_b", bus_b_data, 16'hBEEF);
        cyc();
        chk_ctl("same_idle", 1'b0, 1'b1);
        chk("same_hold", bus_a_data, 16'hBEEF);

        // Write-to-capture bypass
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
        rd_req = 1'b1; rd_addr_a = 4'd5; rd_addr_b = 4'd3;
        cyc();
        wr_en = 1'b0; rd_req = 1'b0;
        chk("byp_a", bus_a_data, 16'h1234);
        chk("byp_b", bus_b_data, 16'hBEEF);
        cyc();

        // Ungranted read waits and keeps its snapshot across a write
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h00AA;
        cyc();
        wr_en = 1'b0;
        bus_grant = 1'b0; rd_req = 1'b1; rd_addr_a = 4'd2; rd_addr_b = 4'd5;
        cyc();
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h5555;
        rd_addr_a = 4'd3; rd_addr_b = 4'd3;
        chk_ctl("wait1", 1'b0, 1'b0);
        chk("wait1_a", bus_a_data, 16'h00AA);
        cyc();
        wr_en = 1'b0;
        chk_ctl("wait2", 1'b0, 1'b0);
        cyc();
        chk_ctl("wait3", 1'b0, 1'b0);
        chk("wait3_a", bus_a_data, 16'h00AA);
        rd_req = 1'b0; bus_grant = 1'b1;
        cyc();
        chk_ctl("wait_drv", 1'b1, 1'b1);
        chk("wait_drv_a", bus_a_data, 16'h00AA);
        chk("wait_drv_b", bus_b_data, 16'h1234);
        cyc();
        chk_ctl("wait_idle", 1'b0, 1'b1);

        // Back-to-back granted reads
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'h0011;
        cyc();
        wr_en = 1'b0;
        rd_req = 1'b1; rd_addr_a = 4'd1; rd_addr_b = 4'd1;
        cyc();
        chk_ctl("b2b1", 1'b1, 1'b1);
        chk("b2b1_a", bus_a_data, 16'h0011);
        rd_addr_a = 4'd2; rd_addr_b = 4'd2;
        cyc();
        chk_ctl("b2b2", 1'b1, 1'b1);
        chk("b2b2_a", bus_a_data, 16'h5555);
        rd_addr_a = 4'd3; rd_addr_b = 4'd3;
        cyc();
        rd_req = 1'b0;
        chk_ctl("b2b3", 1'b1, 1'b1);
        chk("b2b3_a", bus_a_data, 16'hBEEF);
        cyc();
        chk_ctl("b2b_idle", 1'b0, 1'b1);
        chk("b2b_hold", bus_b_data, 16'hBEEF);

        // Asynchronous reset in WAIT
        bus_grant = 1'b0; rd_req = 1'b1; rd_addr_a = 4'd1; rd_addr_b = 4'd2;
        cyc();
        rd_req = 1'b0;
        chk_ctl("rw_wait", 1'b0, 1'b0);
        chk("rw_wait_a", bus_a_data, 16'h0011);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_a", bus_a_data, 16'h0000);
        chk("rw_b", bus_b_data, 16'h0000);
        chk_ctl("rw", 1'b0, 1'b1);
        #2 rst_n = 1'b1;
        bus_grant = 1'b1;
        cyc();
        chk_ctl("rw_post1", 1'b0, 1'b1);
        cyc();
        chk_ctl("rw_post2", 1'b0, 1'b1);

        // Storage was cleared by reset
        rd_req = 1'b1; rd_addr_a = 4'd1; rd_addr_b = 4'd3;
        cyc();
        rd_req = 1'b0;
        chk_ctl("clr", 1'b1, 1'b1);
        chk("clr_a", bus_a_data, 16'h0000);
        chk("clr_b", bus_b_data, 16'h0000);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
